pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/freeze sequencer for the 5-stage pipeline.
- Drives the write-enable, flush and bubble controls of PC, IF/ID and ID/EX.
- Freezes the whole pipe while data memory is busy.
- Schedules interrupt entry so it never splits a taken branch or jump.
- Keeps a saturating stall-cycle counter for time analysis.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEMWAIT cycles before abort with mem_err.
- IRQ_BLOCK, 4, cycles after irq_ack during which irq_req is ignored.

Ports:
- sysclk  input  1  clock.
- reset  input  1  asynchronous, active-low.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- ex_memread  input  1  instruction in EX is a load.
- ex_rt  input  5  destination of the load in EX.
- ex_branch_taken  input  1  branch resolved taken in EX.
- id_jump  input  1  jump decoded in ID.
- irq_req  input  1  level interrupt request.
- mem_req  input  1  MEM stage accessing data memory this cycle.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID load enable.
- if_flush  output  1  zero IF/ID instruction.
- id_ex_bubble  output  1  zero ID/EX control signals.
- pipe_hold  output  1  hold ID/EX, EX/MEM, MEM/WB.
- irq_ack  output  1  registered one-cycle interrupt-accept pulse.
- mem_err  output  1  registered one-cycle timeout pulse.
- state  output  2  current FSM state.
- stall_count  output  16  cycles with pc_write=0, saturating.

Behaviour:
- FSM states: RUN=0, MEMWAIT=1, IRQ_BLOCK=2. Encoding 3 is unused and returns to RUN.
- Reset (async, low) values:
  - state=RUN; internal counters=0; irq_ack=0; mem_err=0; stall_count=0.
  - Combinational outputs in reset with inputs 0: pc_write=1, if_id_write=1, all others 0.
- Priority each cycle: freeze > branch/jump flush > irq accept > load-use.
- Freeze:
  - Condition: state==MEMWAIT, or state!=MEMWAIT and mem_req=1 and mem_ready=0.
  - Outputs: pc_write=0, if_id_write=0, pipe_hold=1, if_flush=0, id_ex_bubble=0.
  - All other events are ignored and held; the inputs stay stable because the pipe is frozen.
- MEMWAIT transitions:
  - Enter from RUN or IRQ_BLOCK on mem_req=1 and mem_ready=0; the wait counter loads 1.
  - In MEMWAIT, mem_ready=1 releases the freeze combinationally in the same cycle; next state is RUN.
  - If the wait counter reaches MEM_TIMEOUT without mem_ready: mem_err=1 next cycle, next state RUN, counter cleared.
  - An IRQ_BLOCK count in progress resumes from its held value after MEMWAIT.
- Branch/jump flush (not frozen):
  - ex_branch_taken=1 -> if_flush=1 and id_ex_bubble=1 this cycle.
  - Otherwise id_jump=1 -> if_flush=1 only.
- IRQ accept:
  - Condition: state==RUN, irq_req=1, ex_branch_taken=0, id_jump=0, not frozen.
  - Same cycle: if_flush=1, id_ex_bubble=1.
  - Next cycle: irq_ack=1; state=IRQ_BLOCK; block counter=IRQ_BLOCK.
  - A deferred irq stays pending as long as irq_req is held.
- IRQ_BLOCK:
  - Counter decrements each non-frozen cycle; irq_req is ignored.
  - Returns to RUN the cycle after the counter reaches 1.
- Load-use:
  - Condition: not frozen, no flush, no irq accept, ex_memread=1, ex_rt!=0, and (ex_rt==id_rs or ex_rt==id_rt).
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle; no state change.
- stall_count: +1 on every cycle with pc_write=0; holds at 16'hFFFF.
- Reset mid-MEMWAIT or mid-IRQ_BLOCK: immediately RUN, counters cleared, pulses dropped.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rt=5 for 1 cycle.
  - -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle only; stall_count=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
  - -> pipe_hold=1 for 3 cycles; released in the ready cycle; state 1->0; stall_count=3.
- Timeout: mem_ready held 0 with MEM_TIMEOUT=16.
  - -> mem_err pulses once after 16 MEMWAIT cycles; state returns to 0.
- IRQ behind branch: irq_req=1 with ex_branch_taken=1 in the same cycle.
  - Branch cycle -> if_flush=1, id_ex_bubble=1, no ack.
  - Next cycle -> accept with if_flush=1; irq_ack next; state=2 for 4 cycles; a second irq_req during the block is ignored.
- Simultaneous events: ex_branch_taken=1 together with mem_req=1, mem_ready=0.
  - -> freeze only, if_flush=0; after mem_ready the branch flush occurs.
- Reset asserted during MEMWAIT at cycle 2.
  - -> state=0, mem_err=0, stall_count=0; pc_write=1 after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: hazard-detect inputs from the pipeline and the
// stall/flush/freeze controls driven back into it.
interface pipe_hazard_ctrl_if;
  // Inputs: hazard sources seen by the controller
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        id_jump;
  logic        irq_req;
  logic        mem_req;
  logic        mem_ready;
  // Outputs: pipeline register controls and status
  logic        pc_write;
  logic        if_id_write;
  logic        if_flush;
  logic        id_ex_bubble;
  logic        pipe_hold;
  logic        irq_ack;
  logic        mem_err;
  logic [1:0]  state;
  logic [15:0] stall_count;

  // Pipeline side: supplies hazard sources and consumes the controls
  modport master (
    output id_rs, id_rt, ex_memread, ex_rt, ex_branch_taken, id_jump,
           irq_req, mem_req, mem_ready,
    input  pc_write, if_id_write, if_flush, id_ex_bubble, pipe_hold,
           irq_ack, mem_err, state, stall_count
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, ex_memread, ex_rt, ex_branch_taken, id_jump,
           irq_req, mem_req, mem_ready,
    output pc_write, if_id_write, if_flush, id_ex_bubble, pipe_hold,
           irq_ack, mem_err, state, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline.
// Priority each cycle: memory freeze > branch/jump flush > irq accept > load-use.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int IRQ_BLOCK   = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int BW = $clog2(IRQ_BLOCK + 1);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_MEMWAIT   = 2'd1,
    S_IRQ_BLOCK = 2'd2
  } state_t;

  state_t          r_state;
  logic [WW-1:0]   r_wait_cnt;
  logic [BW-1:0]   r_blk_cnt;
  logic            r_irq_ack;
  logic            r_mem_err;
  logic [15:0]     r_stall_cnt;

  logic w_mem_stall;
  logic w_frozen;
  logic w_flush_br;
  logic w_irq_acc;
  logic w_load_use;
  logic w_pc_write;

  assign w_mem_stall = bus.mem_req && !bus.mem_ready;
  // In MEMWAIT only mem_ready releases; elsewhere a fresh unready access freezes.
  assign w_frozen    = (r_state == S_MEMWAIT) ? !bus.mem_ready : w_mem_stall;
  assign w_flush_br  = !w_frozen && (bus.ex_branch_taken || bus.id_jump);
  // Interrupts wait for a clean boundary so a taken branch/jump is never split.
  assign w_irq_acc   = !w_frozen && (r_state == S_RUN) && bus.irq_req &&
                       !bus.ex_branch_taken && !bus.id_jump;
  assign w_load_use  = !w_frozen && !w_flush_br && !w_irq_acc && bus.ex_memread &&
                       (bus.ex_rt != 5'd0) &&
                       ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
  assign w_pc_write  = !(w_frozen || w_load_use);

  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_pc_write;
  assign bus.pipe_hold    = w_frozen;
  assign bus.if_flush     = w_flush_br || w_irq_acc;
  assign bus.id_ex_bubble = !w_frozen &&
                            (bus.ex_branch_taken || w_irq_acc || w_load_use);
  assign bus.irq_ack      = r_irq_ack;
  assign bus.mem_err      = r_mem_err;
  assign bus.state        = r_state;
  assign bus.stall_count  = r_stall_cnt;

  // FSM: memory wait tracking, irq blocking window and registered pulses
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_blk_cnt  <= '0;
      r_irq_ack  <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      r_irq_ack <= w_irq_acc;
      r_mem_err <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_mem_stall) begin
            r_state    <= S_MEMWAIT;
            r_wait_cnt <= WW'(1);
          end else if (w_irq_acc) begin
            r_state   <= S_IRQ_BLOCK;
            r_blk_cnt <= BW'(IRQ_BLOCK);
          end
        end
        S_MEMWAIT: begin
          if (bus.mem_ready) begin
            // A frozen irq window picks up where it left off.
            r_state    <= (r_blk_cnt != '0) ? S_IRQ_BLOCK : S_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WW'(MEM_TIMEOUT)) begin
            // Aborted access: drop back to RUN and discard any irq window.
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_blk_cnt  <= '0;
            r_mem_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
          end
        end
        S_IRQ_BLOCK: begin
          if (w_mem_stall) begin
            r_state    <= S_MEMWAIT;
            r_wait_cnt <= WW'(1);
          end else if (r_blk_cnt <= BW'(1)) begin
            r_state   <= S_RUN;
            r_blk_cnt <= '0;
          end else begin
            r_blk_cnt <= r_blk_cnt - BW'(1);
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Saturating count of cycles where the PC did not advance
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (!w_pc_write && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued per step
// and popped against the DUT mid-cycle.
module tb_pipe_hazard_ctrl;
  logic sysclk = 1'b0;
  logic reset  = 1'b0;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .IRQ_BLOCK(4)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    string       tag;
    logic [6:0]  flags;  // pc_write,if_id_write,if_flush,id_ex_bubble,pipe_hold,irq_ack,mem_err
    logic [1:0]  st;
    logic [15:0] sc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_sc = 16'd0;

  task automatic idle();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.ex_memread = 1'b0; bus.ex_rt = 5'd0;
    bus.ex_branch_taken = 1'b0; bus.id_jump = 1'b0; bus.irq_req = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  // Queue the expectation for this cycle, compare once inputs settle, then
  // advance to the next falling edge.
  task automatic cyc(input string tag, input logic [6:0] f, input logic [1:0] st);
    exp_t e;
    exp_t o;
    logic [6:0] obs_f;
    e.tag = tag; e.flags = f; e.st = st; e.sc = exp_sc;
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    obs_f = {bus.pc_write, bus.if_id_write, bus.if_flush, bus.id_ex_bubble,
             bus.pipe_hold, bus.irq_ack, bus.mem_err};
    checks++;
    assert ({obs_f, bus.state, bus.stall_count} === {o.flags, o.st, o.sc}) else begin
      errors++;
      $error("FAIL %s: observed flags=%b state=%0d stall=%0d, expected flags=%b state=%0d stall=%0d",
             o.tag, obs_f, bus.state, bus.stall_count, o.flags, o.st, o.sc);
    end
    if (!f[6] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    @(negedge sysclk);
  endtask

  localparam logic [6:0] F_RUN   = 7'b1100000;
  localparam logic [6:0] F_HOLD  = 7'b0000100;
  localparam logic [6:0] F_LU    = 7'b0001000;
  localparam logic [6:0] F_BR    = 7'b1111000;
  localparam logic [6:0] F_JMP   = 7'b1110000;
  localparam logic [6:0] F_ACK   = 7'b1100010;
  localparam logic [6:0] F_ERR   = 7'b1100001;

  initial begin
    idle();
    @(negedge sysclk);
    cyc("reset", F_RUN, 2'd0);
    reset = 1'b1;
    cyc("idle", F_RUN, 2'd0);

    // Load-use on rt, then no stall for r0, then load-use on rs
    bus.ex_memread = 1'b1; bus.ex_rt = 5'd5; bus.id_rt = 5'd5;
    cyc("lu_rt", F_LU, 2'd0);
    idle();
    cyc("lu_after", F_RUN, 2'd0);
    bus.ex_memread = 1'b1; bus.ex_rt = 5'd0;
    cyc("lu_r0", F_RUN, 2'd0);
    bus.ex_rt = 5'd7; bus.id_rs = 5'd7;
    cyc("lu_rs", F_LU, 2'd0);
    idle();

    // Memory wait: 3 frozen cycles, released in the ready cycle
    bus.mem_req = 1'b1;
    cyc("mw1", F_HOLD, 2'd0);
    cyc("mw2", F_HOLD, 2'd1);
    cyc("mw3", F_HOLD, 2'd1);
    bus.mem_ready = 1'b1;
    cyc("mw_rdy", F_RUN, 2'd1);
    idle();
    cyc("mw_done", F_RUN, 2'd0);

    // Timeout: 16 MEMWAIT cycles then a single mem_err pulse
    bus.mem_req = 1'b1;
    cyc("to_entry", F_HOLD, 2'd0);
    for (int i = 0; i < 16; i++) cyc("to_wait", F_HOLD, 2'd1);
    idle();
    cyc("to_err", F_ERR, 2'd0);
    cyc("to_clr", F_RUN, 2'd0);

    // IRQ deferred behind a taken branch, then accepted and blocked
    bus.irq_req = 1'b1; bus.ex_branch_taken = 1'b1;
    cyc("irq_br", F_BR, 2'd0);
    bus.ex_branch_taken = 1'b0;
    cyc("irq_acc", F_BR, 2'd0);
    bus.irq_req = 1'b0;
    cyc("irq_ack", F_ACK, 2'd2);
    bus.irq_req = 1'b1;
    cyc("blk2", F_RUN, 2'd2);
    cyc("blk3", F_RUN, 2'd2);
    cyc("blk4", F_RUN, 2'd2);
    bus.irq_req = 1'b0;
    cyc("blk_end", F_RUN, 2'd0);

    // Branch together with a memory stall: freeze only, flush on release
    bus.ex_branch_taken = 1'b1; bus.mem_req = 1'b1;
    cyc("sim_frz", F_HOLD, 2'd0);
    bus.mem_ready = 1'b1;
    cyc("sim_rdy", F_BR, 2'd1);
    idle();
    cyc("sim_done", F_RUN, 2'd0);

    // Jump outranks both irq accept and load-use
    bus.id_jump = 1'b1; bus.irq_req = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_rt = 5'd5; bus.id_rt = 5'd5;
    cyc("jump_pri", F_JMP, 2'd0);
    idle();
    cyc("jump_done", F_RUN, 2'd0);

    // Reset in the middle of a memory wait
    bus.mem_req = 1'b1;
    cyc("rm1", F_HOLD, 2'd0);
    cyc("rm2", F_HOLD, 2'd1);
    reset = 1'b0;
    idle();
    exp_sc = 16'd0;
    cyc("rst_mw", F_RUN, 2'd0);
    reset = 1'b1;
    cyc("post_rst", F_RUN, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
